// File: rtl/pcie_fetch_pkg.sv
// Shared types for the PCIe message fetch read master.
// FSM encoding, AXI constants and the queued descriptor layout.
package pcie_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_RD   = 2'd2
    } state_e;

    localparam int         BEAT_BYTES     = 32;
    localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [3:0]  tag;
        logic [11:0] len;
    } desc_t;

endpackage

// File: rtl/pcie_desc_fifo.sv
// Synchronous descriptor FIFO with full/empty flags.
// A push while full is accepted only when a pop happens the same cycle.
module pcie_desc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Read/write pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // Storage array, no reset needed since empty flag guards reads
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/pcie_msg_fetch.sv
// AXI read master fetching assembled PCIe messages from per-tag SRAM slots.
// Optional counters enabled by defining PCIE_FETCH_STATS_EN.
module pcie_msg_fetch
    import pcie_fetch_pkg::*;
#(
    parameter int         DESC_DEPTH = 8,
    parameter int         MAX_BURST  = 16,
    parameter int         SLOT_BEATS = 64,
    parameter logic [6:0] ID_VAL     = 7'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         asm_valid,
    input  logic [3:0]   asm_tag,
    input  logic [11:0]  asm_len,
    output logic [6:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [6:0]   rid,
    input  logic [255:0] rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic         out_valid,
    output logic [255:0] out_data,
    output logic [3:0]   out_tag,
    output logic         out_last,
    output logic         out_err,
    input  logic         out_ready,
    output logic [7:0]   drop_cnt,
    output logic         err_sticky,
    output logic [15:0]  stat_msg_cnt,
    output logic [31:0]  stat_beat_cnt
);

    localparam logic [11:0] MAX_B      = 12'(MAX_BURST);
    localparam logic [11:0] SLOT_B     = 12'(SLOT_BEATS);
    localparam logic [31:0] SLOT_BYTES = 32'(SLOT_BEATS * BEAT_BYTES);
    localparam logic [31:0] BEAT_B32   = 32'(BEAT_BYTES);

    state_e      state_q, state_d;
    logic [3:0]  tag_q, tag_d;
    logic [11:0] rem_q, rem_d;
    logic [11:0] burst_q, burst_d;
    logic [11:0] beat_q, beat_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  drop_q, drop_d;
    logic        err_q, err_d;

    desc_t       push_desc;
    desc_t       pop_desc;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        drop_ev;
    logic        clamp_ev;
    logic        in_rd;
    logic        r_hs;
    logic        burst_end;
    logic        msg_end;
    logic [11:0] burst_w;
    logic        unused_rid;

    assign unused_rid = ^rid;

    assign clamp_ev      = asm_valid && (asm_len > SLOT_B);
    assign push_desc.tag = asm_tag;
    assign push_desc.len = (asm_len > SLOT_B) ? SLOT_B : asm_len;
    assign fifo_push     = asm_valid && (asm_len != 12'd0);
    assign fifo_pop      = (state_q == S_IDLE) && !fifo_empty;
    assign drop_ev       = asm_valid &&
                           ((asm_len == 12'd0) ||
                            (fifo_full && !fifo_pop));

    pcie_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .W     ($bits(desc_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (push_desc),
        .pop_i   (fifo_pop),
        .data_o  (pop_desc),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign burst_w   = (rem_q > MAX_B) ? MAX_B : rem_q;
    assign in_rd     = (state_q == S_RD);
    assign r_hs      = in_rd && rvalid && out_ready;
    assign burst_end = (beat_q == burst_q - 12'd1);
    assign msg_end   = burst_end && (rem_q == burst_q);

    assign arid      = ID_VAL;
    assign arsize    = AXI_SIZE_32B;
    assign arburst   = AXI_BURST_INCR;
    assign arvalid   = (state_q == S_AR);
    assign araddr    = arvalid ? addr_q : '0;
    assign arlen     = arvalid ? 8'(burst_w - 12'd1) : '0;

    assign rready    = in_rd && out_ready;
    assign out_valid = in_rd && rvalid;
    assign out_data  = in_rd ? rdata : '0;
    assign out_tag   = tag_q;
    assign out_last  = out_valid && msg_end;
    assign out_err   = out_valid && (rresp != 2'b00);

    assign drop_cnt   = drop_q;
    assign err_sticky = err_q;

    // Fetch sequencing: pop descriptor, issue bursts, count beats
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    tag_d   = pop_desc.tag;
                    rem_d   = pop_desc.len;
                    addr_d  = 32'(pop_desc.tag) * SLOT_BYTES;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    burst_d = burst_w;
                    beat_d  = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (r_hs) begin
                    if (burst_end) begin
                        rem_d   = rem_q - burst_q;
                        addr_d  = addr_q + 32'(burst_q) * BEAT_B32;
                        beat_d  = '0;
                        state_d = msg_end ? S_IDLE : S_AR;
                    end else begin
                        beat_d = beat_q + 12'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating drop counter and sticky error collection
    always_comb begin
        drop_d = drop_q;
        if (drop_ev && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        err_d = err_q | drop_ev | clamp_ev |
                (r_hs && (rresp != 2'b00)) |
                (r_hs && (rlast != burst_end));
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

`ifdef PCIE_FETCH_STATS_EN
    logic [15:0] msg_cnt_q;
    logic [31:0] beat_cnt_q;

    // Wrapping message and beat counters on output handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
            if (out_last) msg_cnt_q <= msg_cnt_q + 16'd1;
        end
    end

    assign stat_msg_cnt  = msg_cnt_q;
    assign stat_beat_cnt = beat_cnt_q;
`else
    assign stat_msg_cnt  = '0;
    assign stat_beat_cnt = '0;
`endif

endmodule
